// File: rtl/index_display_driver.sv
// index_display_driver
//   Shows the current image index as a hex digit on a 4-digit common-anode
//   seven-segment display. The digits are scanned one at a time. After every
//   index change, digit 3 and the digit-0 decimal point flash briefly to show
//   the direction of the step (forward / backward / jump).
//
// Parameters
//   INDEX_W      width of image_index (1..4)
//   REFRESH_DIV  clk cycles each digit is held active (>= 2)
//   FLASH_CYCLES length of the change-indicator window in clk cycles (>= 1)
//
// Ports
//   clk          system clock
//   reset        synchronous reset, active-low
//   image_index  current image index, synchronous to clk
//   an           digit enables, active-low, an[0] = rightmost digit
//   seg          segments {g,f,e,d,c,b,a}, active-low
//   dp           decimal point, active-low
module index_display_driver #(
  parameter int unsigned INDEX_W      = 2,
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned FLASH_CYCLES = 50000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INDEX_W-1:0] image_index,
  output logic [3:0]         an,
  output logic [6:0]         seg,
  output logic               dp
);

  localparam int unsigned CntW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned TimerW = $clog2(FLASH_CYCLES + 1);

  localparam logic [CntW-1:0]   RefreshLast = CntW'(REFRESH_DIV - 1);
  localparam logic [TimerW-1:0] FlashLoad   = TimerW'(FLASH_CYCLES);

  localparam logic [6:0] SegBlank = 7'b1111111;
  localparam logic [6:0] SegFwd   = 7'b1111110;  // only a
  localparam logic [6:0] SegBwd   = 7'b1110111;  // only d
  localparam logic [6:0] SegJump  = 7'b0111111;  // only g

  typedef enum logic [1:0] {DirNone, DirFwd, DirBwd, DirJump} dir_e;

  logic [CntW-1:0]    refresh_cnt_q, refresh_cnt_d;
  logic [1:0]         digit_sel_q, digit_sel_d;
  logic [INDEX_W-1:0] idx_q, idx_d;
  logic [TimerW-1:0]  timer_q, timer_d;
  dir_e               dir_q, dir_d;
  logic               first_q, first_d;
  logic [3:0]         an_q, an_d;
  logic [6:0]         seg_q, seg_d;
  logic               dp_q, dp_d;

  logic               change;
  logic               flash_active;
  logic [INDEX_W-1:0] idx_inc, idx_dec;

  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    logic [6:0] g;
    g = SegBlank;
    case (v)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;
      4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    return g;
  endfunction

  // Change detection, direction and flash timer.
  always_comb begin
    idx_d   = image_index;
    first_d = 1'b0;
    timer_d = timer_q;
    dir_d   = dir_q;

    idx_inc = idx_q + INDEX_W'(1);
    idx_dec = idx_q - INDEX_W'(1);
    // The load right after reset is not a user action, so it never flashes.
    change  = (image_index != idx_q) && !first_q;

    if (change) begin
      timer_d = FlashLoad;
      // Forward is tested first so it wins when +1 and -1 coincide (INDEX_W=1).
      if (image_index == idx_inc) begin
        dir_d = DirFwd;
      end else if (image_index == idx_dec) begin
        dir_d = DirBwd;
      end else begin
        dir_d = DirJump;
      end
    end else if (timer_q != '0) begin
      timer_d = timer_q - TimerW'(1);
    end
  end

  // Digit scan.
  always_comb begin
    refresh_cnt_d = refresh_cnt_q + CntW'(1);
    digit_sel_d   = digit_sel_q;
    if (refresh_cnt_q == RefreshLast) begin
      refresh_cnt_d = '0;
      digit_sel_d   = digit_sel_q + 2'd1;
    end
  end

  // Output decode, registered so image_index never reaches a pin combinationally.
  always_comb begin
    flash_active = (timer_q != '0);
    an_d         = ~(4'b0001 << digit_sel_q);
    seg_d        = SegBlank;
    dp_d         = 1'b1;

    unique case (digit_sel_q)
      2'd0: begin
        seg_d = hex_glyph(4'(idx_q));
        dp_d  = !flash_active;
      end
      2'd1, 2'd2: seg_d = SegBlank;
      2'd3: begin
        if (flash_active) begin
          case (dir_q)
            DirFwd:  seg_d = SegFwd;
            DirBwd:  seg_d = SegBwd;
            DirJump: seg_d = SegJump;
            default: seg_d = SegBlank;
          endcase
        end
      end
      default: seg_d = SegBlank;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      refresh_cnt_q <= '0;
      digit_sel_q   <= 2'd0;
      idx_q         <= '0;
      timer_q       <= '0;
      dir_q         <= DirNone;
      first_q       <= 1'b1;
      an_q          <= 4'b1111;
      seg_q         <= SegBlank;
      dp_q          <= 1'b1;
    end else begin
      refresh_cnt_q <= refresh_cnt_d;
      digit_sel_q   <= digit_sel_d;
      idx_q         <= idx_d;
      timer_q       <= timer_d;
      dir_q         <= dir_d;
      first_q       <= first_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_index_display_driver.sv
// Directed bench for index_display_driver with REFRESH_DIV=4, FLASH_CYCLES=10.
// Cycle n counts rising edges after reset release; outputs are sampled 1 ns
// after each edge. An index change applied after edge k becomes visible at
// n = k+2 (glyph and flash), and the flash stays visible for 10 cycles.
module tb_index_display_driver;

  localparam int Flash = 10;

  localparam logic [6:0] GFwd  = 7'b1111110;
  localparam logic [6:0] GBwd  = 7'b1110111;
  localparam logic [6:0] GJmp  = 7'b0111111;

  logic       clk;
  logic       reset;
  logic [1:0] image_index;
  logic [0:0] idx1;
  logic [3:0] an, an1;
  logic [6:0] seg, seg1;
  logic       dp, dp1;

  int compared;
  int mismatched;

  index_display_driver #(
    .INDEX_W      (2),
    .REFRESH_DIV  (4),
    .FLASH_CYCLES (10)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .image_index (image_index),
    .an          (an),
    .seg         (seg),
    .dp          (dp)
  );

  index_display_driver #(
    .INDEX_W      (1),
    .REFRESH_DIV  (4),
    .FLASH_CYCLES (10)
  ) u_dut1 (
    .clk         (clk),
    .reset       (reset),
    .image_index (idx1),
    .an          (an1),
    .seg         (seg1),
    .dp          (dp1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] hex(input int v);
    case (v)
      0:       return 7'b1000000;
      1:       return 7'b1111001;
      2:       return 7'b0100100;
      3:       return 7'b0110000;
      default: return 7'b0000000;
    endcase
  endfunction

  // Expected {an, seg, dp} at cycle n. v1/v2 are visibility cycles of up to
  // two index changes (0 = no change).
  function automatic logic [11:0] expect_out(input int n, input int old_i,
                                             input int v1, input int new1, input logic [6:0] d1,
                                             input int v2, input int new2, input logic [6:0] d2);
    int         digit;
    int         shown;
    logic       flash;
    logic [6:0] dg;
    logic [3:0] a;
    logic [6:0] s;
    logic       p;
    digit = ((n - 1) / 4) % 4;
    if (n <= 1) shown = 0;
    else if (v2 != 0 && n >= v2) shown = new2;
    else if (v1 != 0 && n >= v1) shown = new1;
    else shown = old_i;
    flash = (v1 != 0 && n >= v1 && n <= v1 + Flash - 1) ||
            (v2 != 0 && n >= v2 && n <= v2 + Flash - 1);
    dg = (v2 != 0 && n >= v2) ? d2 : d1;
    a = 4'b1111;
    a[digit] = 1'b0;
    s = 7'b1111111;
    if (digit == 0) s = hex(shown);
    else if (digit == 3 && flash) s = dg;
    p = !(digit == 0 && flash);
    return {a, s, p};
  endfunction

  task automatic do_reset(input logic [1:0] i0, input logic i1);
    reset       = 1'b0;
    image_index = i0;
    idx1        = i1;
    for (int c = 0; c < 3; c++) begin
      tick();
      compared++;
      if ({an, seg, dp} !== 12'b1111_1111111_1) begin
        mismatched++;
        $display("FAIL reset cyc=%0d got an=%b seg=%b dp=%b want 1111 1111111 1", c, an, seg, dp);
      end
      compared++;
      if ({an1, seg1, dp1} !== 12'b1111_1111111_1) begin
        mismatched++;
        $display("FAIL reset_w1 cyc=%0d got an=%b seg=%b dp=%b want 1111 1111111 1",
                 c, an1, seg1, dp1);
      end
    end
    reset = 1'b1;
  endtask

  task automatic test_reset_scan();
    logic [11:0] e;
    do_reset(2'd0, 1'b0);
    for (int n = 1; n <= 36; n++) begin
      tick();
      e = expect_out(n, 0, 0, 0, GFwd, 0, 0, GFwd);
      compared++;
      if ({an, seg, dp} !== e) begin
        mismatched++;
        $display("FAIL scan n=%0d got %b_%b_%b want %b", n, an, seg, dp, e);
      end
      compared++;
      if ({an1, seg1, dp1} !== e) begin
        mismatched++;
        $display("FAIL scan_w1 n=%0d got %b_%b_%b want %b", n, an1, seg1, dp1, e);
      end
    end
  endtask

  task automatic test_forward();
    logic [11:0] e;
    do_reset(2'd1, 1'b0);
    for (int n = 1; n <= 24; n++) begin
      tick();
      e = expect_out(n, 1, 10, 2, GFwd, 0, 0, GFwd);
      compared++;
      if ({an, seg, dp} !== e) begin
        mismatched++;
        $display("FAIL forward n=%0d got %b_%b_%b want %b", n, an, seg, dp, e);
      end
      if (n == 8) image_index = 2'd2;
    end
  endtask

  task automatic test_wrap();
    logic [1:0]  from_t [3] = '{2'd3, 2'd0, 2'd0};
    logic [1:0]  to_t   [3] = '{2'd0, 2'd3, 2'd2};
    logic [6:0]  dir_t  [3] = '{GFwd, GBwd, GJmp};
    logic [11:0] e;
    for (int t = 0; t < 3; t++) begin
      do_reset(from_t[t], 1'b0);
      for (int n = 1; n <= 20; n++) begin
        tick();
        e = expect_out(n, int'(from_t[t]), 14, int'(to_t[t]), dir_t[t], 0, 0, GFwd);
        compared++;
        if ({an, seg, dp} !== e) begin
          mismatched++;
          $display("FAIL wrap%0d n=%0d got %b_%b_%b want %b", t, n, an, seg, dp, e);
        end
        if (n == 12) image_index = to_t[t];
      end
    end
  endtask

  task automatic test_retrigger();
    logic [11:0] e;
    do_reset(2'd1, 1'b0);
    for (int n = 1; n <= 40; n++) begin
      tick();
      e = expect_out(n, 1, 19, 2, GFwd, 25, 1, GBwd);
      compared++;
      if ({an, seg, dp} !== e) begin
        mismatched++;
        $display("FAIL retrigger n=%0d got %b_%b_%b want %b", n, an, seg, dp, e);
      end
      if (n == 17) image_index = 2'd2;
      if (n == 23) image_index = 2'd1;
    end
  endtask

  task automatic test_first_sample();
    logic [11:0] e;
    do_reset(2'd3, 1'b0);
    for (int n = 1; n <= 20; n++) begin
      tick();
      e = expect_out(n, 3, 0, 0, GFwd, 0, 0, GFwd);
      compared++;
      if ({an, seg, dp} !== e) begin
        mismatched++;
        $display("FAIL first_sample n=%0d got %b_%b_%b want %b", n, an, seg, dp, e);
      end
    end
  endtask

  task automatic test_reset_mid_flash();
    logic [11:0] e;
    do_reset(2'd1, 1'b0);
    for (int n = 1; n <= 14; n++) begin
      tick();
      e = expect_out(n, 1, 10, 2, GFwd, 0, 0, GFwd);
      compared++;
      if ({an, seg, dp} !== e) begin
        mismatched++;
        $display("FAIL pre_reset n=%0d got %b_%b_%b want %b", n, an, seg, dp, e);
      end
      if (n == 8) image_index = 2'd2;
    end
    reset = 1'b0;
    tick();
    compared++;
    if ({an, seg, dp} !== 12'b1111_1111111_1) begin
      mismatched++;
      $display("FAIL mid_reset got an=%b seg=%b dp=%b want 1111 1111111 1", an, seg, dp);
    end
    reset = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      e = expect_out(n, 2, 0, 0, GFwd, 0, 0, GFwd);
      compared++;
      if ({an, seg, dp} !== e) begin
        mismatched++;
        $display("FAIL post_reset n=%0d got %b_%b_%b want %b", n, an, seg, dp, e);
      end
    end
  endtask

  task automatic test_index_w1();
    logic [11:0] e;
    do_reset(2'd0, 1'b0);
    for (int n = 1; n <= 40; n++) begin
      tick();
      e = expect_out(n, 0, 10, 1, GFwd, 26, 0, GFwd);
      compared++;
      if ({an1, seg1, dp1} !== e) begin
        mismatched++;
        $display("FAIL w1 n=%0d got %b_%b_%b want %b", n, an1, seg1, dp1, e);
      end
      if (n == 8)  idx1 = 1'b1;
      if (n == 24) idx1 = 1'b0;
    end
  endtask

  initial begin
    compared    = 0;
    mismatched  = 0;
    reset       = 1'b0;
    image_index = 2'd0;
    idx1        = 1'b0;
    test_reset_scan();
    test_forward();
    test_wrap();
    test_retrigger();
    test_first_sample();
    test_reset_mid_flash();
    test_index_w1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
